// File: rtl/countdown_timer.sv
// Loadable down-counter with one-shot / auto-reload modes, pause/resume and a
// registered single-cycle expiry pulse. The decrement is a half-subtractor ripple.
module countdown_timer #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_value,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  auto_reload,
  output logic [DATA_WIDTH-1:0] count,
  output logic                  busy,
  output logic                  expire,
  output logic                  borrow
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } state_t;

  localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1);

  state_t                  state_q;
  logic [DATA_WIDTH-1:0]   reload_q;
  logic [DATA_WIDTH-1:0]   count_q;
  logic                    busy_q;
  logic                    expire_q;

  logic [DATA_WIDTH-1:0]   reload_d;
  logic [DATA_WIDTH-1:0]   count_dec;
  logic                    at_terminal;

  // A start coinciding with load must see the value being written this cycle.
  assign reload_d    = load ? load_value : reload_q;
  assign at_terminal = (count_q == ONE);

  // count - 1 as a borrow chain; the final borrow-out is never needed because
  // RUN never decrements from zero.
  always_comb begin
    logic b;
    b         = 1'b1;
    count_dec = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      count_dec[i] = count_q[i] ^ b;
      b            = b & ~count_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      reload_q <= '0;
      count_q  <= '0;
      busy_q   <= 1'b0;
      expire_q <= 1'b0;
    end else begin
      expire_q <= 1'b0;
      reload_q <= reload_d;
      case (state_q)
        IDLE: begin
          if (load) begin
            count_q <= load_value;
          end
          // stop outranks start, so a simultaneous stop suppresses the start.
          if (start && !stop) begin
            if (reload_d != '0) begin
              state_q <= RUN;
              busy_q  <= 1'b1;
              count_q <= reload_d;
            end else begin
              count_q  <= '0;
              expire_q <= 1'b1;
            end
          end
        end

        RUN: begin
          if (at_terminal) begin
            expire_q <= 1'b1;
            // The terminal reload uses the register value, not a same-cycle load.
            if (auto_reload && (reload_q != '0)) begin
              count_q <= reload_q;
              if (stop) begin
                state_q <= PAUSED;
              end
            end else begin
              count_q <= '0;
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else if (stop) begin
            state_q <= PAUSED;
          end else begin
            count_q <= count_dec;
          end
        end

        PAUSED: begin
          if (stop) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (start) begin
            state_q <= RUN;
          end
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign count  = count_q;
  assign busy   = busy_q;
  assign expire = expire_q;
  assign borrow = (count_q == '0);

endmodule
